// File: rtl/axi_ram_bridge_pkg.sv
// Shared AXI response codes and FSM state types for the RAM-facing bridges.
package axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_RESP
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_ACK,
    W_RESP
  } wr_state_e;

endpackage

// File: rtl/axi_ram_bridge_if.sv
// AXI4-Lite channel bundle between a master and the RAM bridge slave.
interface axi_ram_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);

  logic [ADDR_W-1:0]   s_araddr;
  logic                s_arvalid;
  logic                s_arready;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rvalid;
  logic                s_rready;
  logic [ADDR_W-1:0]   s_awaddr;
  logic                s_awvalid;
  logic                s_awready;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_wvalid;
  logic                s_wready;
  logic [1:0]          s_bresp;
  logic                s_bvalid;
  logic                s_bready;

  modport master (
    output s_araddr, s_arvalid, s_rready,
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_arready, s_rdata, s_rresp, s_rvalid,
    input  s_awready, s_wready, s_bresp, s_bvalid
  );

  modport slave (
    input  s_araddr, s_arvalid, s_rready,
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_arready, s_rdata, s_rresp, s_rvalid,
    output s_awready, s_wready, s_bresp, s_bvalid
  );

endinterface

// File: rtl/axi_ram_bridge_strb2mask.sv
// Expands per-byte write strobes into a per-bit write mask.
module axi_strb2mask #(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W/8-1:0] strb_i,
  output logic [DATA_W-1:0]   mask_o
);

  always_comb begin
    mask_o = '0;
    for (int unsigned i = 0; i < DATA_W/8; i++) begin
      mask_o[i*8 +: 8] = {8{strb_i[i]}};
    end
  end

endmodule

// File: rtl/axi_ram_bridge.sv
// AXI4-Lite slave in front of the data RAM: decodes the window, rebases the
// address and drives the RAM strobe interface with independent read/write FSMs.
module axi_ram_bridge
  import axi_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 64,
  parameter logic [ADDR_W-1:0] ADDR_BASE = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] ADDR_SIZE = 32'h0080_0000
) (
  input  logic              clk,
  input  logic              rst,
  axi_ram_bridge_if.slave   s,
  output logic [ADDR_W-1:0] ram_raddr_o,
  output logic              ram_ren_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  input  logic              ram_rready_i,
  output logic [ADDR_W-1:0] ram_waddr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic [DATA_W-1:0] ram_wmask_o,
  output logic              ram_wen_o,
  input  logic              ram_wready_i,
  input  logic              ram_bvalid_i
);

  // One extra bit so BASE+SIZE at the top of the address space cannot wrap.
  function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] ax, lo, hi;
    ax = {1'b0, a};
    lo = {1'b0, ADDR_BASE};
    hi = lo + {1'b0, ADDR_SIZE};
    return (ax >= lo) && (ax < hi);
  endfunction

  rd_state_e           rd_state_q, rd_state_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic                rhit_q, rhit_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;

  wr_state_e           wr_state_q, wr_state_d;
  logic                aw_got_q, aw_got_d;
  logic                w_got_q, w_got_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic                whit_q, whit_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [DATA_W-1:0]   wmask;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      raddr_q    <= '0;
      rhit_q     <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= AXI_RESP_OKAY;
      wr_state_q <= W_IDLE;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      waddr_q    <= '0;
      whit_q     <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= AXI_RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      raddr_q    <= raddr_d;
      rhit_q     <= rhit_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_state_q <= wr_state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      waddr_q    <= waddr_d;
      whit_q     <= whit_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
    end
  end

  // Outputs are forced low while rst is high so no strobe escapes the reset cycle.
  always_comb begin
    rd_state_d  = rd_state_q;
    raddr_d     = raddr_q;
    rhit_d      = rhit_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    s.s_arready = 1'b0;
    s.s_rvalid  = 1'b0;
    ram_ren_o   = 1'b0;
    if (!rst) begin
      case (rd_state_q)
        R_IDLE: begin
          s.s_arready = 1'b1;
          if (s.s_arvalid) begin
            raddr_d    = s.s_araddr - ADDR_BASE;
            rhit_d     = addr_hit(s.s_araddr);
            rd_state_d = R_REQ;
          end
        end
        R_REQ: begin
          if (rhit_q) begin
            ram_ren_o = 1'b1;
            if (ram_rready_i) begin
              rdata_d    = ram_rdata_i;
              rresp_d    = AXI_RESP_OKAY;
              rd_state_d = R_RESP;
            end
          end else begin
            rdata_d    = '0;
            rresp_d    = AXI_RESP_DECERR;
            rd_state_d = R_RESP;
          end
        end
        R_RESP: begin
          s.s_rvalid = 1'b1;
          if (s.s_rready) rd_state_d = R_IDLE;
        end
        default: rd_state_d = R_IDLE;
      endcase
    end
  end

  assign s.s_rdata   = rdata_q;
  assign s.s_rresp   = rresp_q;
  assign ram_raddr_o = raddr_q;

  // AW and W are captured independently; the *_d copies let a same-cycle
  // pair (or the second of a split pair) launch the request immediately.
  always_comb begin
    wr_state_d  = wr_state_q;
    aw_got_d    = aw_got_q;
    w_got_d     = w_got_q;
    waddr_d     = waddr_q;
    whit_d      = whit_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bresp_d     = bresp_q;
    s.s_awready = 1'b0;
    s.s_wready  = 1'b0;
    s.s_bvalid  = 1'b0;
    ram_wen_o   = 1'b0;
    if (!rst) begin
      case (wr_state_q)
        W_IDLE: begin
          s.s_awready = !aw_got_q;
          s.s_wready  = !w_got_q;
          if (s.s_awvalid && !aw_got_q) begin
            waddr_d  = s.s_awaddr - ADDR_BASE;
            whit_d   = addr_hit(s.s_awaddr);
            aw_got_d = 1'b1;
          end
          if (s.s_wvalid && !w_got_q) begin
            wdata_d = s.s_wdata;
            wstrb_d = s.s_wstrb;
            w_got_d = 1'b1;
          end
          if (aw_got_d && w_got_d) begin
            aw_got_d = 1'b0;
            w_got_d  = 1'b0;
            if (whit_d) begin
              wr_state_d = W_REQ;
            end else begin
              bresp_d    = AXI_RESP_DECERR;
              wr_state_d = W_RESP;
            end
          end
        end
        W_REQ: begin
          if (ram_wready_i) begin
            ram_wen_o  = 1'b1;
            wr_state_d = W_ACK;
          end
        end
        W_ACK: begin
          if (ram_bvalid_i) begin
            bresp_d    = AXI_RESP_OKAY;
            wr_state_d = W_RESP;
          end
        end
        W_RESP: begin
          s.s_bvalid = 1'b1;
          if (s.s_bready) wr_state_d = W_IDLE;
        end
        default: wr_state_d = W_IDLE;
      endcase
    end
  end

  axi_strb2mask #(.DATA_W(DATA_W)) u_strb2mask (
    .strb_i (wstrb_q),
    .mask_o (wmask)
  );

  assign s.s_bresp   = bresp_q;
  assign ram_waddr_o = waddr_q;
  assign ram_wmask_o = wmask;
  assign ram_wdata_o = wdata_q & wmask;

endmodule

// File: tb/tb_axi_ram_bridge.sv
// Bench for axi_ram_bridge: directed scenarios plus a random mix of reads and
// writes checked against a word-array model of the RAM window.
module tb_axi_ram_bridge;
  import axi_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SIZE = 32'h0080_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_ram_bridge_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  logic [31:0] ram_raddr_o, ram_waddr_o;
  logic        ram_ren_o, ram_wen_o, ram_rready_i, ram_wready_i;
  logic [63:0] ram_rdata_i, ram_wdata_o, ram_wmask_o;
  logic        ram_bvalid_i = 1'b0;

  axi_ram_bridge #(
    .ADDR_W(32), .DATA_W(64), .ADDR_BASE(BASE), .ADDR_SIZE(SIZE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s            (bus),
    .ram_raddr_o  (ram_raddr_o),
    .ram_ren_o    (ram_ren_o),
    .ram_rdata_i  (ram_rdata_i),
    .ram_rready_i (ram_rready_i),
    .ram_waddr_o  (ram_waddr_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_wmask_o  (ram_wmask_o),
    .ram_wen_o    (ram_wen_o),
    .ram_wready_i (ram_wready_i),
    .ram_bvalid_i (ram_bvalid_i)
  );

  // RAM device model (aliased to 256 words) and event recorders
  logic [63:0] mem [256];
  logic [63:0] ref_mem [256];
  logic        mem_init = 1'b0, bd_we = 1'b0;
  logic [7:0]  bd_idx = '0;
  logic [63:0] bd_data = '0;
  logic        stall_en = 1'b0, r_force = 1'b1, w_force = 1'b1;
  logic        rnd_r = 1'b1, rnd_w = 1'b1;
  int unsigned wen_cnt = 0, ren_cyc = 0;
  logic [31:0] last_waddr = '0, last_raddr = '0;
  logic [63:0] last_wmask = '0, last_wdata = '0;
  int total = 0, bad = 0;

  assign ram_rready_i = stall_en ? rnd_r : r_force;
  assign ram_wready_i = stall_en ? rnd_w : w_force;
  assign ram_rdata_i  = mem[ram_raddr_o[10:3]];

  function automatic logic [63:0] init_word(input int i);
    return {32'h5A5A_0000 ^ 32'(i), 32'hC0DE_0000 + 32'(i)};
  endfunction

  always @(posedge clk) begin
    rnd_r        <= 1'($urandom_range(0, 1));
    rnd_w        <= 1'($urandom_range(0, 1));
    ram_bvalid_i <= ram_wen_o;
    if (ram_wen_o) begin
      wen_cnt    <= wen_cnt + 1;
      last_waddr <= ram_waddr_o;
      last_wmask <= ram_wmask_o;
      last_wdata <= ram_wdata_o;
    end
    if (ram_ren_o) ren_cyc <= ren_cyc + 1;
    if (ram_ren_o && ram_rready_i) last_raddr <= ram_raddr_o;
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i[7:0]] <= init_word(i);
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else if (ram_wen_o) begin
      mem[ram_waddr_o[10:3]] <= (mem[ram_waddr_o[10:3]] & ~ram_wmask_o) | ram_wdata_o;
    end
  end

  function automatic logic is_hit(input logic [31:0] a);
    longint v;
    v = longint'(a);
    return (v >= 64'sh8000_0000) && (v < 64'sh8080_0000);
  endfunction

  function automatic logic [7:0] idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[10:3];
  endfunction

  function automatic logic [63:0] strb_mask(input logic [7:0] st);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) if (st[i]) m = m | (64'hFF << (8 * i));
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic backdoor(input logic [31:0] a, input logic [63:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx(a); bd_data = d;
    ref_mem[idx(a)] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int rdly, output int lat);
    logic        hit;
    logic [63:0] exp_d;
    logic [1:0]  exp_r;
    int          n;
    int unsigned ren0;
    hit  = is_hit(addr);
    ren0 = ren_cyc;
    @(negedge clk);
    bus.s_araddr = addr; bus.s_arvalid = 1'b1; bus.s_rready = 1'b0;
    n = 0;
    while (!bus.s_arready && n < 20) begin @(negedge clk); n++; end
    chk("ar_handshake", 64'(n < 20), 64'd1);
    exp_d = hit ? ref_mem[idx(addr)] : 64'd0;
    exp_r = hit ? AXI_RESP_OKAY : AXI_RESP_DECERR;
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    lat = 1;
    while (!bus.s_rvalid && lat < 30) begin @(negedge clk); lat++; end
    chk("rvalid_seen", 64'(lat < 30), 64'd1);
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      chk("rvalid_hold", 64'(bus.s_rvalid), 64'd1);
      chk("rdata_hold", bus.s_rdata, exp_d);
      chk("arready_stall", 64'(bus.s_arready), 64'd0);
    end
    chk("rdata", bus.s_rdata, exp_d);
    chk("rresp", 64'(bus.s_rresp), 64'(exp_r));
    bus.s_rready = 1'b1;
    @(negedge clk);
    bus.s_rready = 1'b0;
    chk("ren_seen", 64'(ren_cyc != ren0), 64'(hit));
    if (hit) chk("raddr", 64'(last_raddr), 64'(addr - BASE));
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, input int aw_dly, input int w_dly,
                           input int bdly, output logic [1:0] resp);
    logic        hit, aw_done, w_done, prev_bv;
    logic [63:0] mask;
    int          n;
    int unsigned wen0;
    hit = is_hit(addr);
    mask = strb_mask(strb);
    wen0 = wen_cnt;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 40) begin
      @(negedge clk);
      bus.s_awaddr = addr; bus.s_wdata = data; bus.s_wstrb = strb;
      bus.s_awvalid = !aw_done && (n >= aw_dly);
      bus.s_wvalid  = !w_done && (n >= w_dly);
      if (bus.s_awvalid && bus.s_awready) aw_done = 1'b1;
      if (bus.s_wvalid && bus.s_wready) w_done = 1'b1;
      n++;
    end
    chk("aw_w_handshake", 64'(aw_done && w_done), 64'd1);
    @(negedge clk);
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    prev_bv = 1'b0; n = 0;
    while (!bus.s_bvalid && n < 40) begin
      prev_bv = ram_bvalid_i;
      @(negedge clk);
      n++;
    end
    chk("bvalid_seen", 64'(n < 40), 64'd1);
    if (hit) chk("b_after_ram_bvalid", 64'(prev_bv), 64'd1);
    for (int i = 0; i < bdly; i++) begin
      @(negedge clk);
      chk("bvalid_hold", 64'(bus.s_bvalid), 64'd1);
      chk("awready_stall", 64'(bus.s_awready), 64'd0);
      chk("wready_stall", 64'(bus.s_wready), 64'd0);
    end
    resp = bus.s_bresp;
    chk("bresp", 64'(resp), 64'(hit ? AXI_RESP_OKAY : AXI_RESP_DECERR));
    bus.s_bready = 1'b1;
    @(negedge clk);
    bus.s_bready = 1'b0;
    chk("wen_pulses", 64'(wen_cnt - wen0), 64'(hit ? 1 : 0));
    if (hit) begin
      chk("waddr", 64'(last_waddr), 64'(addr - BASE));
      chk("wmask", last_wmask, mask);
      chk("wdata", last_wdata, data & mask);
      ref_mem[idx(addr)] = (ref_mem[idx(addr)] & ~mask) | (data & mask);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat, lat2;
    logic [1:0]  resp, resp2;
    logic [31:0] a;
    int unsigned wen0;
    bus.s_araddr = '0; bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0;
    bus.s_wstrb = '0; bus.s_wvalid = 1'b0; bus.s_bready = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i[7:0]] = init_word(i);

    // reset values
    mem_init = 1'b1;
    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    chk("rst_ready_valid", 64'({bus.s_arready, bus.s_rvalid, bus.s_awready,
                                bus.s_wready, bus.s_bvalid}), 64'd0);
    chk("rst_ram_strobes", 64'({ram_ren_o, ram_wen_o}), 64'd0);
    chk("rst_rdata", bus.s_rdata, 64'd0);
    chk("rst_resps", 64'({bus.s_rresp, bus.s_bresp}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_readies", 64'({bus.s_arready, bus.s_awready, bus.s_wready}), 64'b111);

    // read hit with minimum latency
    backdoor(BASE + 32'h10, 64'h1122334455667788);
    axi_read(BASE + 32'h10, 0, lat);
    chk("read_latency", 64'(lat), 64'd2);

    // W two cycles ahead of AW
    axi_write(BASE + 32'h20, 64'hDEADBEEFCAFEF00D, 8'h0F, 2, 0, 0, resp);
    axi_read(BASE + 32'h20, 0, lat);

    // decode boundaries
    axi_read(32'h7FFF_FFF8, 0, lat);
    axi_read(BASE + SIZE - 32'd8, 0, lat);
    axi_read(BASE + SIZE, 0, lat);
    axi_write(32'h8080_0000, 64'h0123456789ABCDEF, 8'hFF, 0, 0, 0, resp);
    axi_write(32'h7FFF_FFF8, 64'h0123456789ABCDEF, 8'hFF, 1, 0, 0, resp);

    // backpressure on R and B
    axi_read(BASE + 32'h10, 5, lat);
    axi_write(BASE + 32'h28, 64'hA5A5_5A5A_0F0F_F0F0, 8'hC3, 0, 1, 5, resp);

    // zero strobes still pulse wen with an empty mask
    axi_write(BASE + 32'h28, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 0, 0, resp);
    axi_read(BASE + 32'h28, 0, lat);

    // same-cycle read and write to one word: read sees old data
    fork
      axi_read(BASE + 32'h40, 0, lat);
      axi_write(BASE + 32'h40, 64'hFEED_FACE_0BAD_BEEF, 8'hFF, 0, 0, 0, resp2);
    join
    axi_read(BASE + 32'h40, 0, lat2);

    // reset while the write waits in the RAM request state
    w_force = 1'b0;
    wen0 = wen_cnt;
    @(negedge clk);
    bus.s_awaddr = BASE + 32'h30; bus.s_awvalid = 1'b1;
    bus.s_wdata = 64'h1111_2222_3333_4444; bus.s_wstrb = 8'hFF; bus.s_wvalid = 1'b1;
    @(negedge clk);
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1; w_force = 1'b1;
    #1;
    chk("wen_in_rst_cycle", 64'(ram_wen_o), 64'd0);
    @(negedge clk);
    chk("midrst_ready_valid", 64'({bus.s_arready, bus.s_rvalid, bus.s_awready,
                                   bus.s_wready, bus.s_bvalid}), 64'd0);
    chk("midrst_strobes", 64'({ram_ren_o, ram_wen_o}), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_wen", 64'(wen_cnt - wen0), 64'd0);
    chk("midrst_bvalid", 64'(bus.s_bvalid), 64'd0);
    axi_read(BASE + 32'h30, 0, lat);

    // random traffic with RAM-side stalls
    stall_en = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 4) != 0) begin
        a = BASE + {21'd0, 8'($urandom_range(0, 255)), 3'b000};
      end else begin
        case ($urandom_range(0, 3))
          0: a = BASE - 32'(8 * $urandom_range(1, 4));
          1: a = BASE + SIZE + 32'(8 * $urandom_range(0, 4));
          2: a = $urandom & 32'h7FFF_FFF8;
          default: a = 32'hFFFF_FFF8;
        endcase
      end
      if ($urandom_range(0, 1) == 1)
        axi_read(a, $urandom_range(0, 2), lat);
      else
        axi_write(a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 2),
                  $urandom_range(0, 2), $urandom_range(0, 2), resp);
    end
    stall_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
